// File: rtl/garage_input_conditioner.sv
// Front end for the garage door FSM: synchronises and debounces the button, remote and limit
// switches, then turns a debounced request into a single ACTIVATE pulse followed by a lockout.
module garage_input_conditioner #(
  parameter int DEB_CYCLES     = 16,
  parameter int HOLDOFF_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_raw_i,
  input  logic rmt_raw_i,
  input  logic up_lim_raw_i,
  input  logic dn_lim_raw_i,
  output logic activate_o,
  output logic up_max_o,
  output logic dn_max_o,
  output logic sensor_fault_o
);

  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF, WAIT_REL} state_t;

  // Channel order: 0 button, 1 remote, 2 up limit, 3 down limit.
  logic [3:0]          rawIn;
  logic [3:0]          sync1_q, sync2_q;
  logic [3:0]          stable_q, stable_d;
  logic [3:0][DW-1:0]  debCnt_q, debCnt_d;
  state_t              state_q, state_d;
  logic [HW-1:0]       holdCnt_q, holdCnt_d;
  logic                activate_q, activate_d;
  logic                fault_q, fault_d;
  logic                req, flt;

  assign rawIn = {dn_lim_raw_i, up_lim_raw_i, rmt_raw_i, btn_raw_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= rawIn;
      sync2_q <= sync1_q;
    end
  end

  // A mismatch must persist for DEB_CYCLES consecutive edges; any reversion restarts the count.
  always_comb begin
    stable_d = stable_q;
    debCnt_d = '0;
    for (int ch = 0; ch < 4; ch++) begin
      if (sync2_q[ch] != stable_q[ch]) begin
        if (debCnt_q[ch] == DW'(DEB_CYCLES - 1)) begin
          stable_d[ch] = sync2_q[ch];
        end else begin
          debCnt_d[ch] = debCnt_q[ch] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stable_q <= '0;
      debCnt_q <= '0;
    end else begin
      stable_q <= stable_d;
      debCnt_q <= debCnt_d;
    end
  end

  assign req = stable_q[0] | stable_q[1];
  assign flt = stable_q[2] & stable_q[3];

  always_comb begin
    state_d   = state_q;
    holdCnt_d = holdCnt_q;
    case (state_q)
      IDLE: begin
        if (req && !flt) begin
          state_d = PULSE;
        end else if (req) begin
          state_d = WAIT_REL;
        end
      end
      PULSE: begin
        state_d   = HOLDOFF;
        holdCnt_d = HW'(HOLDOFF_CYCLES - 1);
      end
      HOLDOFF: begin
        if (holdCnt_q == '0) begin
          state_d = req ? WAIT_REL : IDLE;
        end else begin
          holdCnt_d = holdCnt_q - 1'b1;
        end
      end
      WAIT_REL: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    activate_d = (state_d == PULSE);
    fault_d    = flt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      holdCnt_q  <= '0;
      activate_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      holdCnt_q  <= holdCnt_d;
      activate_q <= activate_d;
      fault_q    <= fault_d;
    end
  end

  assign activate_o     = activate_q;
  assign up_max_o       = stable_q[2];
  assign dn_max_o       = stable_q[3];
  assign sensor_fault_o = fault_q;

endmodule

// File: tb/tb_garage_input_conditioner.sv
// Scoreboard bench for garage_input_conditioner: a time-based reference model predicts every
// cycle's outputs into a queue that an independent monitor drains and compares.
module tb_garage_input_conditioner;

  localparam int DEB  = 16;
  localparam int HOLD = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic btn   = 1'b0;
  logic rmt   = 1'b0;
  logic upl   = 1'b0;
  logic dnl   = 1'b0;
  logic act, upm, dnm, flt;

  always #5 clk = ~clk;

  garage_input_conditioner #(.DEB_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .btn_raw_i      (btn),
    .rmt_raw_i      (rmt),
    .up_lim_raw_i   (upl),
    .dn_lim_raw_i   (dnl),
    .activate_o     (act),
    .up_max_o       (upm),
    .dn_max_o       (dnm),
    .sensor_fault_o (flt)
  );

  typedef struct packed {
    logic act;
    logic up;
    logic dn;
    logic flt;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   checks = 0;
  int   fails = 0;
  int   pulsesSeen = 0;
  int   pulsesExpected = 0;
  bit   monitorOn = 1'b0;

  // Reference model state: raw delay line, accepted levels, run lengths, pulse timing.
  bit [3:0] rawD1, rawD2, stb, runVal;
  int       runLen[4];
  int       edgeNo;
  int       lastPulse;
  bit       waitRel;

  function automatic void modelReset();
    rawD1 = '0;
    rawD2 = '0;
    stb = '0;
    runVal = '0;
    for (int ch = 0; ch < 4; ch++) runLen[ch] = 0;
    edgeNo = 0;
    lastPulse = -1000;
    waitRel = 1'b0;
  endfunction

  // Predicts the outputs visible after the next rising edge, given the raw levels sampled there.
  function automatic void modelEdge(input bit [3:0] raw);
    bit [3:0] s;
    bit req, f, pulse;
    edgeNo++;
    s = rawD2;
    rawD2 = rawD1;
    rawD1 = raw;
    req = stb[0] | stb[1];
    f = stb[2] & stb[3];
    pulse = 1'b0;
    if (edgeNo == lastPulse + HOLD + 1) begin
      waitRel = req;
    end else if (edgeNo >= lastPulse + HOLD + 2) begin
      if (waitRel) begin
        if (!req) waitRel = 1'b0;
      end else if (req && !f) begin
        pulse = 1'b1;
        lastPulse = edgeNo;
      end else if (req && f) begin
        waitRel = 1'b1;
      end
    end
    for (int ch = 0; ch < 4; ch++) begin
      if (s[ch] == runVal[ch]) begin
        runLen[ch]++;
      end else begin
        runVal[ch] = s[ch];
        runLen[ch] = 1;
      end
      if (runVal[ch] != stb[ch] && runLen[ch] >= DEB) stb[ch] = runVal[ch];
    end
    if (pulse) pulsesExpected++;
    expQ.push_back('{act: pulse, up: stb[2], dn: stb[3], flt: f});
  endfunction

  task automatic checkOutput(input string name, input logic [3:0] actual, input logic [3:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b (act,up,dn,fault) at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one raw pattern for n edges; inputs change 2 time units after each rising edge.
  task automatic applyStimulus(input bit b, input bit r, input bit u, input bit d, input int n);
    for (int k = 0; k < n; k++) begin
      btn = b;
      rmt = r;
      upl = u;
      dnl = d;
      modelEdge({d, u, r, b});
      @(posedge clk);
      #2;
    end
  endtask

  task automatic doReset();
    monitorOn = 1'b0;
    rst_n = 1'b0;
    expQ.delete();
    modelReset();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    monitorOn = 1'b1;
  endtask

  always @(posedge clk) begin
    #1;
    if (monitorOn && rst_n && expQ.size() > 0) begin
      monExp = expQ.pop_front();
      checkOutput("outputs", {act, upm, dnm, flt}, monExp);
      if (act === 1'b1) pulsesSeen++;
    end
  end

  initial begin
    modelReset();

    // All inputs high through reset: limits accepted at edge 18, fault at 19, no pulse.
    btn = 1; rmt = 1; upl = 1; dnl = 1;
    repeat (2) @(posedge clk);
    #3;
    checkOutput("reset_outputs", {act, upm, dnm, flt}, 4'b0000);
    doReset();
    applyStimulus(1, 1, 1, 1, 17);
    checkOutput("lim_edge17", {act, upm, dnm, flt}, 4'b0000);
    applyStimulus(1, 1, 1, 1, 1);
    checkOutput("lim_edge18", {act, upm, dnm, flt}, 4'b0110);
    applyStimulus(1, 1, 1, 1, 1);
    checkOutput("fault_edge19", {act, upm, dnm, flt}, 4'b0111);
    applyStimulus(1, 1, 1, 1, 30);
    applyStimulus(0, 0, 0, 0, 30);

    // Clean press: pulse after exactly edge 19, then re-press after holdoff.
    btn = 0; rmt = 0; upl = 0; dnl = 0;
    doReset();
    applyStimulus(1, 0, 0, 0, 18);
    checkOutput("act_edge18", {act, upm, dnm, flt}, 4'b0000);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("act_edge19", {act, upm, dnm, flt}, 4'b1000);
    applyStimulus(1, 0, 0, 0, 1);
    checkOutput("act_edge20", {act, upm, dnm, flt}, 4'b0000);
    applyStimulus(1, 0, 0, 0, 80);
    applyStimulus(0, 0, 0, 0, 90);
    applyStimulus(1, 0, 0, 0, 30);
    applyStimulus(0, 0, 0, 0, 30);

    // Bouncing button, then held.
    doReset();
    for (int i = 0; i < 12; i++) applyStimulus(i % 2 == 0, 0, 0, 0, 5);
    applyStimulus(1, 0, 0, 0, 30);
    applyStimulus(0, 0, 0, 0, 30);

    // Re-press inside holdoff and held past its end, then a fresh press.
    doReset();
    applyStimulus(1, 0, 0, 0, 30);
    applyStimulus(0, 0, 0, 0, 10);
    applyStimulus(1, 0, 0, 0, 60);
    applyStimulus(0, 0, 0, 0, 30);
    applyStimulus(1, 0, 0, 0, 30);
    applyStimulus(0, 0, 0, 0, 90);

    // Overlapping and simultaneous sources.
    doReset();
    applyStimulus(1, 0, 0, 0, 50);
    applyStimulus(1, 1, 0, 0, 100);
    applyStimulus(0, 0, 0, 0, 40);
    applyStimulus(1, 1, 0, 0, 40);
    applyStimulus(0, 0, 0, 0, 90);

    // Both limits active inhibit activation; recovery needs release and a fresh press.
    doReset();
    applyStimulus(0, 0, 1, 1, 30);
    applyStimulus(1, 0, 1, 1, 40);
    applyStimulus(1, 0, 1, 0, 40);
    applyStimulus(0, 0, 1, 0, 30);
    applyStimulus(1, 0, 1, 0, 30);
    applyStimulus(0, 0, 0, 0, 90);

    // Reset asserted while ACTIVATE is high must clear it without a clock edge.
    doReset();
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, 0, 0, 0, 1);
      if (act === 1'b1) break;
    end
    checkOutput("pulse_before_reset", {act, 3'b000}, 4'b1000);
    monitorOn = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("act_async_reset", {act, upm, dnm, flt}, 4'b0000);
    btn = 0;

    // Randomised segments, including single-cycle glitches and occasional double-limit faults.
    doReset();
    for (int i = 0; i < 60; i++) begin
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(1, 40));
    end
    applyStimulus(0, 0, 0, 0, 5);
    @(posedge clk);
    #2;

    checkOutput("queue_drained", 4'(expQ.size()), 4'd0);
    checks++;
    if (pulsesSeen != pulsesExpected) begin
      fails++;
      $display("[TB] FAIL pulse_count: got %0d, expected %0d", pulsesSeen, pulsesExpected);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
